drawing_control_fsm_multislot: RTL and testbench



---
 rtl/drawing_control_fsm_multislot.sv | 164 ++++++++++++++++
 tb/tb_drawing_control_fsm_multislot.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/drawing_control_fsm_multislot.sv
// Control FSM for the drawing circuit: mouse-driven move/draw/erase/clear plus NUM_SLOTS slot
// save/load. Define DRAW_TIMEOUT_EN to add the busy-state watchdog (oTimeout).
module drawing_control_fsm_multislot #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned SLOT_W         = 2,
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iBtnL,
    input  logic                 iBtnR,
    input  logic                 iMove,
    input  logic                 iClear,
    input  logic                 iDone,
    input  logic [NUM_SLOTS-1:0] iSlotReq,
    input  logic                 iSaveMode,
    output logic [4:0]           oState,
    output logic                 oEnableMouse,
    output logic                 oStartTransmission,
    output logic                 oDatapathSelect,
    output logic [SLOT_W-1:0]    oSlotIdx,
    output logic                 oMemSave,
    output logic                 oBusy,
    output logic                 oTimeout
);

    typedef enum logic [4:0] {
        StIdle       = 5'd0,
        StMove       = 5'd1,
        StWait       = 5'd2,
        StClean      = 5'd3,
        StDraw       = 5'd4,
        StErase      = 5'd5,
        StClearWait  = 5'd6,
        StClear      = 5'd7,
        StResetMouse = 5'd8,
        StSlotWait   = 5'd9,
        StSlotOp     = 5'd10,
        StInitWait   = 5'd11,
        StInitClear  = 5'd12
    } stateT;

    if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        SLOT_W != ((NUM_SLOTS <= 2) ? 1 : $clog2(NUM_SLOTS))) begin : gBadParams
        $error("drawing_control_fsm_multislot: illegal parameter combination");
    end

    stateT             stateQ, stateD;
    logic [SLOT_W-1:0] idxQ, idxD, lowIdx;
    logic              saveQ, saveD;
    logic [15:0]       waitQ, waitD;
    logic              timeoutD;
`ifdef DRAW_TIMEOUT_EN
    logic [31:0]       wdQ, wdD;
    logic              watched;
`endif

    // Lowest-numbered requesting slot wins.
    always_comb begin
        lowIdx = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (iSlotReq[i]) lowIdx = SLOT_W'(i);
        end
    end

    always_comb begin
        stateD   = stateQ;
        idxD     = idxQ;
        saveD    = saveQ;
        waitD    = waitQ;
        timeoutD = 1'b0;
        case (stateQ)
            StIdle: begin
                if (|iSlotReq) begin
                    stateD = StSlotWait;
                    idxD   = lowIdx;
                    saveD  = iSaveMode;
                end else if (iMove) begin
                    stateD = StMove;
                    waitD  = '0;
                end else if (iBtnL) begin
                    stateD = StDraw;
                end else if (iBtnR) begin
                    stateD = StErase;
                end else if (iClear) begin
                    stateD = StClearWait;
                end
            end
            StMove: begin
                waitD = '0;
                if (iDone) stateD = StWait;
            end
            StWait: begin
                if (waitQ == 16'(WAIT_CYCLES - 1)) stateD = StClean;
                else waitD = waitQ + 16'd1;
            end
            StClean, StDraw, StErase, StClear, StSlotOp: begin
                if (iDone) stateD = StIdle;
            end
            StClearWait:  if (!iClear) stateD = StClear;
            StResetMouse: stateD = StIdle;
            StSlotWait:   if (!iSlotReq[idxQ]) stateD = StSlotOp;
            StInitWait:   stateD = StInitClear;
            StInitClear: begin
                if (iDone) begin
                    if (idxQ == SLOT_W'(NUM_SLOTS - 1)) begin
                        stateD = StResetMouse;
                    end else begin
                        idxD   = idxQ + SLOT_W'(1);
                        stateD = StInitWait;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
`ifdef DRAW_TIMEOUT_EN
        watched = stateQ inside {StMove, StClean, StDraw, StErase, StClear, StSlotOp, StInitClear};
        if (watched && !iDone && wdQ == 32'(TIMEOUT_CYCLES - 1)) begin
            stateD   = (stateQ == StInitClear) ? StResetMouse : StIdle;
            timeoutD = 1'b1;
        end
        wdD = (stateD != stateQ) ? '0 : wdQ + 32'd1;
`endif
    end

    // Outputs are decoded from the next-state values so they register alongside the state.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateQ             <= StInitWait;
            idxQ               <= '0;
            saveQ              <= 1'b0;
            waitQ              <= '0;
            oDatapathSelect    <= 1'b1;
            oSlotIdx           <= '0;
            oMemSave           <= 1'b0;
            oStartTransmission <= 1'b0;
            oEnableMouse       <= 1'b1;
            oBusy              <= 1'b1;
            oTimeout           <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
            wdQ                <= '0;
`endif
        end else begin
            stateQ             <= stateD;
            idxQ               <= idxD;
            saveQ              <= saveD;
            waitQ              <= waitD;
            oDatapathSelect    <= stateD inside {StInitWait, StInitClear, StSlotWait, StSlotOp};
            oSlotIdx           <= idxD;
            oMemSave           <= (stateD == StInitClear) ? 1'b1 : saveD;
            oStartTransmission <= (stateD == StResetMouse);
            oEnableMouse       <= 1'b1;
            oBusy              <= (stateD != StIdle);
            oTimeout           <= timeoutD;
`ifdef DRAW_TIMEOUT_EN
            wdQ                <= wdD;
`endif
        end
    end

    assign oState = stateQ;

endmodule

// File: tb/tb_drawing_control_fsm_multislot.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-level model.
module tb_drawing_control_fsm_multislot;

    localparam int NS   = 4;
    localparam int SW   = 2;
    localparam int WC   = 3;
    localparam int TOC  = 16;

    logic          iClk = 1'b0;
    logic          iReset, iBtnL, iBtnR, iMove, iClear, iDone, iSaveMode;
    logic [NS-1:0] iSlotReq;
    logic [4:0]    oState;
    logic          oEnableMouse, oStartTransmission, oDatapathSelect, oMemSave, oBusy, oTimeout;
    logic [SW-1:0] oSlotIdx;

    drawing_control_fsm_multislot #(
        .NUM_SLOTS(NS), .SLOT_W(SW), .WAIT_CYCLES(WC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .iClk(iClk), .iReset(iReset), .iBtnL(iBtnL), .iBtnR(iBtnR), .iMove(iMove),
        .iClear(iClear), .iDone(iDone), .iSlotReq(iSlotReq), .iSaveMode(iSaveMode),
        .oState(oState), .oEnableMouse(oEnableMouse), .oStartTransmission(oStartTransmission),
        .oDatapathSelect(oDatapathSelect), .oSlotIdx(oSlotIdx), .oMemSave(oMemSave),
        .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state number, latched slot/save, cycles spent in the current state.
    int mState, mIdx, mSave, mAge, mTmo, ns;
    bit modelValid = 0;

    function automatic int lowestSlot(input logic [NS-1:0] req);
        for (int i = 0; i < NS; i++) if (req[i]) return i;
        return 0;
    endfunction

    always @(posedge iClk) begin
        if (iReset) begin
            mState = 11; mIdx = 0; mSave = 0; mAge = 0; mTmo = 0;
            modelValid = 1;
        end else if (modelValid) begin
            ns   = mState;
            mTmo = 0;
            case (mState)
                0: begin
                    if (iSlotReq != 0) begin
                        ns = 9; mIdx = lowestSlot(iSlotReq); mSave = int'(iSaveMode);
                    end else if (iMove)  ns = 1;
                    else if (iBtnL)      ns = 4;
                    else if (iBtnR)      ns = 5;
                    else if (iClear)     ns = 6;
                end
                1:             if (iDone) ns = 2;
                2:             if (mAge == WC - 1) ns = 3;
                3, 4, 5, 7, 10: if (iDone) ns = 0;
                6:             if (!iClear) ns = 7;
                8:             ns = 0;
                9:             if (!iSlotReq[mIdx]) ns = 10;
                11:            ns = 12;
                12: if (iDone) begin
                    if (mIdx == NS - 1) ns = 8;
                    else begin mIdx = mIdx + 1; ns = 11; end
                end
                default: ns = 0;
            endcase
`ifdef DRAW_TIMEOUT_EN
            if (mState inside {1, 3, 4, 5, 7, 10, 12} && !iDone && mAge == TOC - 1) begin
                ns = (mState == 12) ? 8 : 0;
                mTmo = 1;
            end
`endif
            mAge   = (ns == mState) ? mAge + 1 : 0;
            mState = ns;
        end
        #1;
        if (modelValid) begin
            check("state",  int'(oState), mState);
            check("enMouse", int'(oEnableMouse), 1);
            check("startTx", int'(oStartTransmission), int'(mState == 8));
            check("dpSel",  int'(oDatapathSelect), int'(mState inside {9, 10, 11, 12}));
            check("slotIdx", int'(oSlotIdx), mIdx);
            check("memSave", int'(oMemSave), (mState == 12) ? 1 : mSave);
            check("busy",   int'(oBusy), int'(mState != 0));
            check("timeout", int'(oTimeout), mTmo);
        end
    end

    task automatic tick();
        @(negedge iClk);
    endtask

    task automatic clearInputs();
        iBtnL = 0; iBtnR = 0; iMove = 0; iClear = 0; iDone = 0; iSlotReq = '0; iSaveMode = 0;
    endtask

    task automatic waitState(input int target, input int budget);
        int n = 0;
        while (int'(oState) != target && n < budget) begin tick(); n++; end
        if (int'(oState) != target) check("waitState", int'(oState), target);
    endtask

    task automatic pulseDone();
        iDone = 1; tick(); iDone = 0;
    endtask

    int n, strobes, doneProb;

    initial begin
        clearInputs();
        iReset = 1;
        tick(); tick();
        check("rst state", int'(oState), 11);
        check("rst idx", int'(oSlotIdx), 0);
        check("rst busy", int'(oBusy), 1);
        check("rst dpSel", int'(oDatapathSelect), 1);
        check("rst save", int'(oMemSave), 0);
        iReset = 0;

        // Power-up clear of every slot, then the mouse-enable strobe.
        for (int s = 0; s < NS; s++) begin
            waitState(12, 20);
            check("init idx", int'(oSlotIdx), s);
            check("init save", int'(oMemSave), 1);
            tick(); tick();
            pulseDone();
        end
        strobes = 0;
        for (int i = 0; i < 6; i++) begin strobes += int'(oStartTransmission); tick(); end
        check("init strobes", strobes, 1);
        check("init end state", int'(oState), 0);

        // Save to slot 1 (lowest of 4'b1010), held 5 cycles.
        iSlotReq = 4'b1010; iSaveMode = 1;
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); n += int'(oState == 5'd9); end
        check("slotWait cycles", n, 5);
        iSlotReq = '0; iSaveMode = 0;
        tick();
        check("slotOp state", int'(oState), 10);
        check("slotOp idx", int'(oSlotIdx), 1);
        check("slotOp save", int'(oMemSave), 1);
        tick(); tick();
        pulseDone();
        check("slot back idle", int'(oState), 0);

        // Move beats draw; WAIT lasts WC cycles.
        iMove = 1; iBtnL = 1;
        tick();
        clearInputs();
        check("move chosen", int'(oState), 1);
        pulseDone();
        n = 0;
        while (int'(oState) == 2 && n < 20) begin n++; tick(); end
        check("wait cycles", n, WC);
        check("clean state", int'(oState), 3);
        pulseDone();
        check("clean idle", int'(oState), 0);

        // Clear held 10 cycles.
        iClear = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(oState == 5'd6 && !oDatapathSelect);
        end
        check("clearWait cycles", n, 10);
        iClear = 0;
        tick();
        check("clear state", int'(oState), 7);
        check("clear dpSel", int'(oDatapathSelect), 0);
        pulseDone();
        check("clear idle", int'(oState), 0);

        // Draw with no completion.
        iBtnL = 1; tick(); iBtnL = 0;
        n = 0;
        while (int'(oState) == 4 && n < 40) begin n++; tick(); end
`ifdef DRAW_TIMEOUT_EN
        check("draw timeout cycles", n, TOC);
        check("timeout pulse", int'(oTimeout), 1);
        tick();
        check("timeout drop", int'(oTimeout), 0);
`else
        check("draw held", n, 40);
        check("no timeout", int'(oTimeout), 0);
        pulseDone();
        check("draw idle", int'(oState), 0);
`endif

        // Reset during SLOT_OP aborts straight to INIT_WAIT.
        iSlotReq = 4'b0100; tick(); iSlotReq = '0; tick();
        check("slotOp2 state", int'(oState), 10);
        check("slotOp2 idx", int'(oSlotIdx), 2);
        iReset = 1; tick(); iReset = 0;
        check("abort state", int'(oState), 11);
        check("abort idx", int'(oSlotIdx), 0);
        check("abort busy", int'(oBusy), 1);

        // Random phase; completion density alternates to exercise long busy periods.
        for (int c = 0; c < 4000; c++) begin
            doneProb  = ((c / 400) % 2 == 1) ? 3 : 35;
            iReset    = ($urandom_range(0, 299) == 0);
            iDone     = ($urandom_range(0, 99) < doneProb);
            iMove     = ($urandom_range(0, 9) == 0);
            iBtnL     = ($urandom_range(0, 9) == 0);
            iBtnR     = ($urandom_range(0, 9) == 0);
            iClear    = ($urandom_range(0, 5) == 0);
            iSaveMode = 1'($urandom);
            iSlotReq  = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
            tick();
        end
        clearInputs();
        iReset = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
